tx_resp_scheduler: RTL

// - Shares the single UART TX path between the two response sources in the REF_CLK domain: register-file reads and ALU results.
// - Queues responses in an entry FIFO and serialises each entry into bytes (ALU results as two bytes, LSB first).
// - Drives the byte-wide TX request toward the REF->UART data synchroniser and paces it using the synchronised TX busy flag.

---
 rtl/tx_resp_scheduler_if.sv | 29 ++
 rtl/tx_resp_scheduler.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/tx_resp_scheduler_if.sv
// Handshake bundle between the REF_CLK response sources, the TX scheduler
// and the REF->UART data synchroniser.
interface tx_resp_scheduler_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ALU_OUT_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]    RdData;
    logic                     RdData_Valid;
    logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
    logic                     ALU_OUT_VALID;
    logic                     TX_Busy;
    logic                     OVF_CLR;
    logic [DATA_WIDTH-1:0]    TX_P_DATA;
    logic                     TX_DATA_VALID;
    logic                     SCH_BUSY;
    logic                     OVERFLOW;

    modport master (
        output RdData, RdData_Valid, ALU_OUT, ALU_OUT_VALID,
        output TX_Busy, OVF_CLR,
        input  TX_P_DATA, TX_DATA_VALID, SCH_BUSY, OVERFLOW
    );

    modport slave (
        input  RdData, RdData_Valid, ALU_OUT, ALU_OUT_VALID,
        input  TX_Busy, OVF_CLR,
        output TX_P_DATA, TX_DATA_VALID, SCH_BUSY, OVERFLOW
    );
endinterface

// File: rtl/tx_resp_scheduler.sv
// Queues register-read and ALU responses and serialises them onto the TX byte path.
// Optional macro TXSCH_TIMEOUT_EN: resend a byte if TX_Busy never rises.
module tx_resp_scheduler #(
    parameter int DATA_WIDTH    = 8,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int PTR_WIDTH     = 2,
    parameter int BUSY_TIMEOUT  = 255
) (
    input  logic                CLK,
    input  logic                RST,
    tx_resp_scheduler_if.slave  bus
);
    localparam int CW = PTR_WIDTH + 1;

    typedef struct packed {
        logic                     is_wide;
        logic [ALU_OUT_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    if (ALU_OUT_WIDTH != 2 * DATA_WIDTH || FIFO_DEPTH != (1 << PTR_WIDTH)
        || FIFO_DEPTH < 2 || BUSY_TIMEOUT < 1) begin : g_bad_cfg
        $error("tx_resp_scheduler: inconsistent parameters");
    end

    entry_t                 mem [FIFO_DEPTH];
    entry_t                 head;
    logic [PTR_WIDTH-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]          count, free_slots;
    logic                   alu_ok, rd_ok, drop;
    logic                   load_lo, load_hi, pop;
    logic                   byte_sel, ovf;
    logic [DATA_WIDTH-1:0]  tx_data;
    state_t                 state, state_nx;

    assign head       = mem[rd_ptr];
    assign free_slots = CW'(FIFO_DEPTH) - count;
    assign alu_ok     = bus.ALU_OUT_VALID && (free_slots != '0);
    // With both strobes the ALU entry takes the first free slot
    assign rd_ok      = bus.RdData_Valid &&
                        (bus.ALU_OUT_VALID ? (free_slots >= CW'(2))
                                           : (free_slots != '0));
    assign drop       = (bus.ALU_OUT_VALID && !alu_ok) ||
                        (bus.RdData_Valid && !rd_ok);

    always_ff @(posedge CLK) begin
        if (alu_ok)
            mem[wr_ptr] <= '{is_wide: 1'b1, data: bus.ALU_OUT};
        if (rd_ok)
            mem[wr_ptr + PTR_WIDTH'(alu_ok)] <=
                '{is_wide: 1'b0, data: ALU_OUT_WIDTH'(bus.RdData)};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PTR_WIDTH'(alu_ok) + PTR_WIDTH'(rd_ok);
            rd_ptr <= rd_ptr + PTR_WIDTH'(pop);
            count  <= count + CW'(alu_ok) + CW'(rd_ok) - CW'(pop);
            if (drop)
                ovf <= 1'b1;
            else if (bus.OVF_CLR)
                ovf <= 1'b0;
        end
    end

`ifdef TXSCH_TIMEOUT_EN
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            tmo_cnt <= '0;
        else if (state == SEND)
            tmo_cnt <= '0;
        else if (state == WAIT_HI)
            tmo_cnt <= tmo_cnt + TW'(1);
    end
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:
                if (count != '0 && !bus.TX_Busy)
                    state_nx = SEND;
            SEND:
                state_nx = WAIT_HI;
            WAIT_HI:
                if (bus.TX_Busy)
                    state_nx = WAIT_LO;
`ifdef TXSCH_TIMEOUT_EN
                else if (tmo_cnt == TW'(BUSY_TIMEOUT))
                    state_nx = SEND;
`endif
            WAIT_LO:
                if (!bus.TX_Busy)
                    state_nx = (head.is_wide && !byte_sel) ? SEND : IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    always_comb begin
        load_lo           = (state == IDLE) && (state_nx == SEND);
        load_hi           = (state == WAIT_LO) && (state_nx == SEND);
        pop               = (state == WAIT_LO) && (state_nx == IDLE);
        bus.TX_DATA_VALID = (state == SEND);
        bus.SCH_BUSY      = (count != '0) || (state != IDLE);
        bus.TX_P_DATA     = tx_data;
        bus.OVERFLOW      = ovf;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_data  <= '0;
            byte_sel <= 1'b0;
        end else if (load_lo) begin
            tx_data  <= head.data[DATA_WIDTH-1:0];
            byte_sel <= 1'b0;
        end else if (load_hi) begin
            tx_data  <= head.data[ALU_OUT_WIDTH-1:DATA_WIDTH];
            byte_sel <= 1'b1;
        end
    end
endmodule
